// File: rtl/cruise_control_if.sv
// Cruise-control bus: driver/sensor inputs and registered actuator/status outputs.
interface cruise_control_if #(
    parameter int W  = 8,
    parameter int PW = 3
);
    logic          engage;
    logic [W-1:0]  speed;
    logic [W-1:0]  vfeli;
    logic [2:0]    hooshyari;
    logic [1:0]    change;

    logic          tormoz;
    logic [PW-1:0] pashesh;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [1:0]    changewire;
    logic [W-1:0]  vout1;
    logic [W-1:0]  vfelinew;
    logic [1:0]    state;
    logic          alarm;

    modport master (
        output engage, speed, vfeli, hooshyari, change,
        input  tormoz, pashesh, gt, eq, lt, changewire, vout1, vfelinew, state, alarm
    );

    modport slave (
        input  engage, speed, vfeli, hooshyari, change,
        output tormoz, pashesh, gt, eq, lt, changewire, vout1, vfelinew, state, alarm
    );
endinterface

// File: rtl/cruise_control_fsm.sv
// Cruise control: set-speed latch, throttle/brake law, drowsiness watchdog forcing braking WARN.
// Latency: one cycle, all outputs registered. Backpressure: none, inputs sampled every clock.
module cruise_control_fsm #(
    parameter int W             = 8,
    parameter int PW            = 3,
    parameter int STEP          = 5,
    parameter int BRAKE_STEP    = 4,
    parameter int SPEED_MAX     = 200,
    parameter int SPEED_MIN     = 30,
    parameter int ALERT_MIN     = 3,
    parameter int DROWSY_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    cruise_control_if.slave bus
);
    localparam int PMAX = 2**PW - 1;
    localparam int WX   = W + 1;
    localparam int CW   = $clog2(DROWSY_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_CRUISE = 2'b01;
    localparam logic [1:0] ST_WARN   = 2'b10;

    localparam logic [1:0] CH_UP     = 2'b01;
    localparam logic [1:0] CH_DOWN   = 2'b10;
    localparam logic [1:0] CH_CANCEL = 2'b11;

    localparam logic [W-1:0]  MAX_W    = W'(SPEED_MAX);
    localparam logic [W-1:0]  MIN_W    = W'(SPEED_MIN);
    localparam logic [W-1:0]  STEP_W   = W'(STEP);
    localparam logic [W-1:0]  BRAKE_W  = W'(BRAKE_STEP);
    localparam logic [WX-1:0] MAX_X    = WX'(SPEED_MAX);
    localparam logic [WX-1:0] MIN_X    = WX'(SPEED_MIN);
    localparam logic [WX-1:0] STEP_X   = WX'(STEP);
    localparam logic [WX-1:0] PMAX_X   = WX'(PMAX);
    localparam logic [2:0]    ALERT_X  = 3'(ALERT_MIN);
    localparam logic [CW-1:0] DROWSY_X = CW'(DROWSY_CYCLES);

    typedef struct packed {
        logic [1:0]    state;
        logic [W-1:0]  vout1;
        logic [W-1:0]  vfelinew;
        logic [PW-1:0] pashesh;
        logic          tormoz;
        logic          alarm;
        logic          gt;
        logic          eq;
        logic          lt;
        logic [1:0]    changewire;
    } out_t;

    out_t          out_q;
    out_t          out_n;
    logic [CW-1:0] drowsy_q;
    logic [CW-1:0] drowsy_n;

    // Comparison always against the set speed held before this edge.
    logic cmp_gt;
    logic cmp_eq;
    logic cmp_lt;
    assign cmp_gt = bus.vfeli >  out_q.vout1;
    assign cmp_eq = bus.vfeli == out_q.vout1;
    assign cmp_lt = bus.vfeli <  out_q.vout1;

    logic [WX-1:0] vfeli_x;
    logic [WX-1:0] vout_x;
    logic [WX-1:0] gap_x;
    logic [WX-1:0] boost_x;
    logic [WX-1:0] inc_x;
    logic [PW-1:0] throttle;
    logic [W-1:0]  boosted;
    logic [W-1:0]  braked;
    logic [W-1:0]  speed_clamped;
    logic [W-1:0]  vout_up;
    logic [W-1:0]  vout_dn;

    assign vfeli_x  = {1'b0, bus.vfeli};
    assign vout_x   = {1'b0, out_q.vout1};
    assign gap_x    = vout_x - vfeli_x;
    assign throttle = (gap_x > PMAX_X) ? PW'(PMAX) : gap_x[PW-1:0];
    assign boost_x  = vfeli_x + WX'(throttle);
    assign boosted  = boost_x[W] ? '1 : boost_x[W-1:0];
    assign braked   = (bus.vfeli >= BRAKE_W) ? bus.vfeli - BRAKE_W : '0;

    assign speed_clamped = (bus.speed < MIN_W) ? MIN_W :
                           (bus.speed > MAX_W) ? MAX_W : bus.speed;
    assign inc_x   = vout_x + STEP_X;
    assign vout_up = (inc_x > MAX_X) ? MAX_W : inc_x[W-1:0];
    assign vout_dn = (vout_x < MIN_X + STEP_X) ? MIN_W : out_q.vout1 - STEP_W;

    logic          drowsy;
    logic          asleep;
    logic [CW-1:0] drowsy_inc;
    assign drowsy     = bus.hooshyari < ALERT_X;
    assign asleep     = bus.hooshyari == 3'd0;
    assign drowsy_inc = (drowsy_q >= DROWSY_X) ? drowsy_q : drowsy_q + CW'(1);

    always_comb begin
        out_n            = '0;
        drowsy_n         = '0;
        out_n.state      = out_q.state;
        out_n.vout1      = out_q.vout1;
        out_n.gt         = cmp_gt;
        out_n.eq         = cmp_eq;
        out_n.lt         = cmp_lt;
        out_n.changewire = bus.change;
        out_n.vfelinew   = bus.vfeli;

        case (out_q.state)
            ST_IDLE: begin
                if (bus.engage && bus.change != CH_CANCEL) begin
                    out_n.vout1 = speed_clamped;
                    out_n.state = ST_CRUISE;
                end
            end
            ST_CRUISE: begin
                if (cmp_lt) begin
                    out_n.pashesh  = throttle;
                    out_n.vfelinew = boosted;
                end else if (cmp_gt) begin
                    out_n.tormoz   = 1'b1;
                    out_n.vfelinew = braked;
                end

                if (bus.change == CH_CANCEL) begin
                    out_n.state = ST_IDLE;
                    out_n.vout1 = '0;
                end else if (asleep || (drowsy && drowsy_inc >= DROWSY_X)) begin
                    out_n.state = ST_WARN;
                end else begin
                    if (drowsy) begin
                        drowsy_n = drowsy_inc;
                    end
                    if (bus.change == CH_UP) begin
                        out_n.vout1 = vout_up;
                    end else if (bus.change == CH_DOWN) begin
                        out_n.vout1 = vout_dn;
                    end
                end
            end
            ST_WARN: begin
                out_n.tormoz   = 1'b1;
                out_n.vfelinew = braked;
                if (bus.change == CH_CANCEL || bus.vfeli <= MIN_W) begin
                    out_n.state = ST_IDLE;
                    out_n.vout1 = '0;
                end else if (!drowsy) begin
                    out_n.state = ST_CRUISE;
                end
            end
            default: begin
                out_n.state = ST_IDLE;
                out_n.vout1 = '0;
            end
        endcase

        out_n.alarm = (out_n.state == ST_WARN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '0;
            drowsy_q <= '0;
        end else begin
            out_q    <= out_n;
            drowsy_q <= drowsy_n;
        end
    end

    assign bus.tormoz     = out_q.tormoz;
    assign bus.pashesh    = out_q.pashesh;
    assign bus.gt         = out_q.gt;
    assign bus.eq         = out_q.eq;
    assign bus.lt         = out_q.lt;
    assign bus.changewire = out_q.changewire;
    assign bus.vout1      = out_q.vout1;
    assign bus.vfelinew   = out_q.vfelinew;
    assign bus.state      = out_q.state;
    assign bus.alarm      = out_q.alarm;

    // The set speed is only ever loaded clamped, so CRUISE can never hold an out-of-range value.
    assert property (@(posedge clock) disable iff (reset) out_q.state != 2'b11);
    assert property (@(posedge clock) disable iff (reset)
        (out_q.state == ST_CRUISE) |-> (vout_x >= MIN_X && vout_x <= MAX_X));
endmodule

// File: tb/tb_cruise_control_fsm.sv
// Bench for cruise_control_fsm: directed scenarios then random traffic against a reference model.
module tb_cruise_control_fsm;
    localparam int W             = 8;
    localparam int PW            = 3;
    localparam int PMAX          = 7;
    localparam int STEP          = 5;
    localparam int BRAKE_STEP    = 4;
    localparam int SPEED_MAX     = 200;
    localparam int SPEED_MIN     = 30;
    localparam int ALERT_MIN     = 3;
    localparam int DROWSY_CYCLES = 4;
    localparam int VTOP          = 255;
    localparam int M_IDLE = 0, M_CRUISE = 1, M_WARN = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          engage;
    logic [W-1:0]  speed;
    logic [W-1:0]  vfeli;
    logic [2:0]    hooshyari;
    logic [1:0]    change;

    int n_cmp = 0;
    int n_bad = 0;

    cruise_control_if #(.W(W), .PW(PW)) bus ();

    assign bus.engage    = engage;
    assign bus.speed     = speed;
    assign bus.vfeli     = vfeli;
    assign bus.hooshyari = hooshyari;
    assign bus.change    = change;

    cruise_control_fsm #(
        .W(W), .PW(PW), .STEP(STEP), .BRAKE_STEP(BRAKE_STEP),
        .SPEED_MAX(SPEED_MAX), .SPEED_MIN(SPEED_MIN),
        .ALERT_MIN(ALERT_MIN), .DROWSY_CYCLES(DROWSY_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: mode, set speed, length of the current drowsy run.
    int m_mode = 0;
    int m_set  = 0;
    int m_run  = 0;
    int x_tormoz, x_pash, x_gt, x_eq, x_lt, x_cw, x_vnew, x_alarm;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int vf  = int'(vfeli);
        int ho  = int'(hooshyari);
        int ch  = int'(change);
        int nxt = m_mode;
        if (reset) begin
            m_mode = M_IDLE; m_set = 0; m_run = 0;
            x_tormoz = 0; x_pash = 0; x_gt = 0; x_eq = 0; x_lt = 0;
            x_cw = 0; x_vnew = 0; x_alarm = 0;
            return;
        end
        x_gt = (vf > m_set) ? 1 : 0;
        x_eq = (vf == m_set) ? 1 : 0;
        x_lt = (vf < m_set) ? 1 : 0;
        x_cw = ch;
        x_tormoz = 0; x_pash = 0; x_vnew = vf;
        if (m_mode == M_IDLE) begin
            if (engage && ch != 3) begin
                m_set = imin(imax(int'(speed), SPEED_MIN), SPEED_MAX);
                nxt = M_CRUISE;
            end
        end else if (m_mode == M_CRUISE) begin
            if (x_lt == 1) x_pash = imin(m_set - vf, PMAX);
            if (x_gt == 1) x_tormoz = 1;
            x_vnew = imin(imax(vf + x_pash - (x_tormoz * BRAKE_STEP), 0), VTOP);
            m_run = (ho < ALERT_MIN) ? m_run + 1 : 0;
            if (ch == 3) begin
                nxt = M_IDLE; m_set = 0;
            end else if (ho == 0 || m_run >= DROWSY_CYCLES) begin
                nxt = M_WARN;
            end else if (ch == 1) begin
                m_set = imin(m_set + STEP, SPEED_MAX);
            end else if (ch == 2) begin
                m_set = imax(m_set - STEP, SPEED_MIN);
            end
        end else begin
            x_tormoz = 1;
            x_vnew = imax(vf - BRAKE_STEP, 0);
            if (ch == 3 || vf <= SPEED_MIN) begin
                nxt = M_IDLE; m_set = 0;
            end else if (ho >= ALERT_MIN) begin
                nxt = M_CRUISE;
            end
        end
        if (nxt != m_mode) m_run = 0;
        m_mode  = nxt;
        x_alarm = (m_mode == M_WARN) ? 1 : 0;
    endtask

    task automatic check_all();
        check("state",      bus.state,      m_mode);
        check("vout1",      bus.vout1,      m_set);
        check("tormoz",     bus.tormoz,     x_tormoz);
        check("pashesh",    bus.pashesh,    x_pash);
        check("gt",         bus.gt,         x_gt);
        check("eq",         bus.eq,         x_eq);
        check("lt",         bus.lt,         x_lt);
        check("changewire", bus.changewire, x_cw);
        check("vfelinew",   bus.vfelinew,   x_vnew);
        check("alarm",      bus.alarm,      x_alarm);
    endtask

    task automatic drive(input int r, input int e, input int spd, input int vf, input int ho, input int ch);
        reset     = (r != 0);
        engage    = (e != 0);
        speed     = W'(spd);
        vfeli     = W'(vf);
        hooshyari = 3'(ho);
        change    = 2'(ch);
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int vf;
        bit sleepy;
        vf = 100;
        sleepy = 1'b0;

        drive(1, 0, 0, 0, 7, 0);
        drive(1, 0, 0, 0, 7, 0);
        check("rst_state", bus.state, 0);
        check("rst_vout1", bus.vout1, 0);

        drive(0, 1, 200, 190, 7, 0);
        check("eng_state", bus.state, 1);
        check("eng_vout1", bus.vout1, 200);
        drive(0, 0, 0, 190, 7, 0);
        check("law_lt", bus.lt, 1);
        check("law_pash", bus.pashesh, 7);
        check("law_torm", bus.tormoz, 0);
        check("law_vnew", bus.vfelinew, 197);

        drive(0, 0, 0, 200, 7, 1);
        check("up_eq", bus.eq, 1);
        check("up_clamp", bus.vout1, 200);
        repeat (3) drive(0, 0, 0, 200, 7, 2);
        check("down3", bus.vout1, 185);
        drive(0, 0, 0, 200, 7, 0);
        check("brk_gt", bus.gt, 1);
        check("brk_torm", bus.tormoz, 1);
        check("brk_vnew", bus.vfelinew, 196);

        repeat (3) drive(0, 0, 0, 200, 2, 0);
        check("drowsy3", bus.state, 1);
        drive(0, 0, 0, 200, 2, 0);
        check("drowsy4", bus.state, 2);
        check("drowsy_alarm", bus.alarm, 1);
        drive(0, 0, 0, 200, 7, 0);
        check("wake_state", bus.state, 1);
        check("wake_alarm", bus.alarm, 0);
        repeat (3) drive(0, 0, 0, 200, 2, 0);
        check("cnt_cleared", bus.state, 1);

        drive(0, 0, 0, 100, 0, 0);
        check("asleep", bus.state, 2);
        drive(0, 0, 0, 40, 0, 0);
        drive(0, 0, 0, 34, 0, 0);
        check("warn_34", bus.state, 2);
        drive(0, 0, 0, 30, 0, 0);
        check("warn_exit", bus.state, 0);
        check("warn_exit_v", bus.vout1, 0);

        drive(0, 1, 10, 100, 7, 0);
        check("clamp_lo", bus.vout1, 30);
        drive(0, 0, 0, 100, 0, 3);
        check("cancel_wins", bus.state, 0);
        check("cancel_cw", bus.changewire, 3);
        drive(0, 1, 90, 100, 7, 3);
        check("eng_cancel", bus.state, 0);

        drive(0, 1, 100, 100, 7, 0);
        drive(0, 0, 0, 100, 0, 0);
        check("pre_rst", bus.state, 2);
        drive(1, 1, 0, 100, 0, 0);
        check("rst_warn", bus.state, 0);
        check("rst_torm", bus.tormoz, 0);
        check("rst_vnew", bus.vfelinew, 0);
        drive(0, 1, 120, 100, 7, 0);
        check("post_rst", bus.state, 1);
        check("post_rst_v", bus.vout1, 120);

        for (int i = 0; i < 3000; i++) begin
            int r, e, ho, ch, spd;
            if ($urandom_range(0, 29) == 0) sleepy = !sleepy;
            vf = vf + int'($urandom_range(0, 12)) - 6;
            if ($urandom_range(0, 49) == 0) vf = int'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) vf = m_set;
            vf  = imin(imax(vf, 0), VTOP);
            ho  = sleepy ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 7));
            ch  = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            spd = int'($urandom_range(0, 255));
            e   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r   = ($urandom_range(0, 199) == 0) ? 1 : 0;
            drive(r, e, spd, vf, ho, ch);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cruise_control_fsm.md
Name: cruise_control_fsm

Overview:
- Parametrised cruise-control core; successor to the single-width `control` block.
- Latches a set speed and compares measured speed against it each cycle.
- Drives throttle level (pashesh) or brake (tormoz) and predicts next speed (vfelinew).
- New in this generation: generic speed/throttle widths, saturating set-speed adjust, cancel, and a driver-alertness (hooshyari) watchdog that forces a braking WARN state.

Parameters:
W, 8, speed/set-speed width
PW, 3, throttle width; PMAX = 2**PW-1
STEP, 5, set-speed increment/decrement per change command
BRAKE_STEP, 4, speed drop modelled per braking cycle
SPEED_MAX, 200, upper clamp for set speed
SPEED_MIN, 30, lower clamp for set speed; WARN exit threshold
ALERT_MIN, 3, hooshyari below this counts as drowsy
DROWSY_CYCLES, 4, consecutive drowsy cycles before WARN

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- engage, input, 1: request to start cruising.
- speed, input, W: requested set speed, sampled on engage.
- vfeli, input, W: current measured speed.
- hooshyari, input, 3: driver alertness; 0 = asleep, 7 = fully alert.
- change, input, 2: 00 hold, 01 +STEP, 10 -STEP, 11 cancel.
- tormoz, output, 1: brake command.
- pashesh, output, PW: throttle level.
- gt / eq / lt, output, 1 each: vfeli vs vout1 (greater / equal / less).
- changewire, output, 2: registered echo of change.
- vout1, output, W: current set speed.
- vfelinew, output, W: predicted next speed.
- state, output, 2: 00 IDLE, 01 CRUISE, 10 WARN.
- alarm, output, 1: high in WARN.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state = IDLE; every output = 0.
- Outputs reflect the inputs sampled at the previous rising edge (1-cycle latency).
- Each edge, in every state, gt/eq/lt are computed from vfeli vs the vout1 value held before this edge's update. Exactly one of the three is 1.
- IDLE:
  - tormoz = 0, pashesh = 0, alarm = 0, vfelinew = vfeli.
  - engage = 1 and change != 11: vout1 <= clamp(speed, SPEED_MIN, SPEED_MAX); go to CRUISE. Otherwise vout1 holds.
- CRUISE, in priority order:
  - change = 11: go to IDLE, vout1 <= 0.
  - hooshyari == 0, or drowsy counter reaching DROWSY_CYCLES this edge: go to WARN.
  - change = 01: vout1 <= min(vout1 + STEP, SPEED_MAX).
  - change = 10: vout1 <= max(vout1 - STEP, SPEED_MIN).
  - Set-speed arithmetic uses W+1 bits internally; no wrap-around is permitted.
- CRUISE control law (uses the pre-update vout1):
  - lt: pashesh = min(vout1 - vfeli, PMAX), tormoz = 0.
  - gt: tormoz = 1, pashesh = 0.
  - eq: tormoz = 0, pashesh = 0.
  - vfelinew = vfeli + pashesh - (tormoz ? BRAKE_STEP : 0), saturated to [0, 2**W-1].
- Drowsy counter:
  - Increments each cycle in CRUISE while hooshyari < ALERT_MIN.
  - Clears to 0 when hooshyari >= ALERT_MIN, and on any state change.
  - Saturates; never wraps.
- WARN:
  - alarm = 1, tormoz = 1, pashesh = 0, vfelinew = max(vfeli - BRAKE_STEP, 0); vout1 holds.
  - change = 11 or vfeli <= SPEED_MIN: go to IDLE, vout1 <= 0.
  - Else hooshyari >= ALERT_MIN: go to CRUISE.
  - Set-speed adjust commands are ignored.
- Reset asserted mid-operation, in any state: return to IDLE with all outputs zero on that edge.
- engage has no effect outside IDLE.
- changewire <= change every cycle, in all states.

Test Plan:
- Reset, then engage = 1, speed = 200, vfeli = 190, hooshyari = 7 → next edge: state CRUISE, vout1 = 200. Following edge: lt = 1, pashesh = 7, tormoz = 0, vfelinew = 197.
- CRUISE, vout1 = 200, vfeli = 200, change = 01 → eq = 1, pashesh = 0, vout1 stays 200 (clamped). Then change = 10 three times → vout1 = 185. Then vfeli = 200 → gt = 1, tormoz = 1, vfelinew = 196.
- CRUISE, hooshyari = 2 for 4 cycles → WARN on the 4th edge, alarm = 1, tormoz = 1. Then hooshyari = 7 → CRUISE next edge, alarm = 0, counter cleared.
- CRUISE, hooshyari = 0 → WARN next edge. vfeli stepping 40, 34, 30 → IDLE on the edge that samples 30, vout1 = 0.
- CRUISE with change = 11 and hooshyari = 0 on the same edge → IDLE (cancel wins); changewire = 11 on the following cycle.
- Reset pulsed for one cycle while in WARN with vfeli = 100 → all outputs 0 and state IDLE on that edge. Engage is honoured on the next cycle after reset deasserts.
